pip_wb_stage: RTL and testbench

- Parametrised MEM/WB pipeline register: successor to the fixed 4-bit-address / 16-bit-data writeback stage register.
- Adds a valid/ready handshake with a 2-entry skid buffer, so register-file write-port back-pressure does not drop results.
- Adds an explicit write-enable, a synchronous flush, and a two-port forwarding lookup for the decode/execute bypass network.
- Sits between the memory stage and the register-file write port.

---
 rtl/pip_pkg.sv | 27 ++
 rtl/pip_wb_stage_if.sv | 40 ++++
 rtl/pip_fwd_cmp.sv | 43 ++++
 rtl/pip_wb_stage.sv | 133 +++++++++++++
 tb/tb_pip_wb_stage.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pip_pkg.sv
// Shared pipeline definitions: stage state encoding, default widths and the
// writeback entry record used by the pipeline stage registers.
package pip_pkg;

    localparam int PIP_AW = 4;
    localparam int PIP_DW = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pip_state_e;

    // Default-width view of a pending register-file write.
    typedef struct packed {
        logic              wen;
        logic [PIP_AW-1:0] addr;
        logic [PIP_DW-1:0] data;
    } pip_entry_t;

    // Writes to a hard-wired zero register are demoted to non-writing entries.
    function automatic logic wen_filter(input logic wen, input logic addr_is_zero,
                                        input logic zero_reg);
        return wen & ~(zero_reg & addr_is_zero);
    endfunction

endpackage

// File: rtl/pip_wb_stage_if.sv
// MEM->WB handshake, register-file write port and bypass lookup signals.
interface pip_wb_stage_if import pip_pkg::*; #(
    parameter int AW = PIP_AW,
    parameter int DW = PIP_DW
) ();

    logic          in_valid;
    logic          in_ready;
    logic          in_wen;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;

    logic          out_valid;
    logic          out_ready;
    logic          out_wen;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;

    logic [AW-1:0] fwd_raddr_a;
    logic [AW-1:0] fwd_raddr_b;
    logic          fwd_hit_a;
    logic          fwd_hit_b;
    logic [DW-1:0] fwd_data_a;
    logic [DW-1:0] fwd_data_b;

    // Upstream / write-port / bypass side.
    modport master (
        output in_valid, in_wen, in_addr, in_data, out_ready, fwd_raddr_a, fwd_raddr_b,
        input  in_ready, out_valid, out_wen, out_addr, out_data,
        input  fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b
    );

    // Stage register side.
    modport slave (
        input  in_valid, in_wen, in_addr, in_data, out_ready, fwd_raddr_a, fwd_raddr_b,
        output in_ready, out_valid, out_wen, out_addr, out_data,
        output fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b
    );

endinterface

// File: rtl/pip_fwd_cmp.sv
// One bypass lookup port: matches a read address against the held head and
// skid entries, the younger skid entry taking priority.
module pip_fwd_cmp #(
    parameter int AW       = 4,
    parameter int DW       = 16,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic          head_valid,
    input  logic          head_wen,
    input  logic [AW-1:0] head_addr,
    input  logic [DW-1:0] head_data,
    input  logic          skid_valid,
    input  logic          skid_wen,
    input  logic [AW-1:0] skid_addr,
    input  logic [DW-1:0] skid_data,
    input  logic [AW-1:0] raddr,
    output logic          hit,
    output logic [DW-1:0] data
);

    logic zero_block;
    logic skid_match;
    logic head_match;

    assign zero_block = ZERO_REG && (raddr == '0);
    assign skid_match = skid_valid && skid_wen && (skid_addr == raddr);
    assign head_match = head_valid && head_wen && (head_addr == raddr);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        if (!zero_block) begin
            if (skid_match) begin
                hit  = 1'b1;
                data = skid_data;
            end else if (head_match) begin
                hit  = 1'b1;
                data = head_data;
            end
        end
    end

endmodule

// File: rtl/pip_wb_stage.sv
// MEM/WB pipeline register with a 2-entry skid buffer, flush, zero-register
// write suppression and a two-port forwarding lookup into the held entries.
module pip_wb_stage import pip_pkg::*; #(
    parameter int AW       = PIP_AW,
    parameter int DW       = PIP_DW,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    pip_wb_stage_if.slave bus
);

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    pip_state_e state_reg, state_next;
    entry_t     head_reg, head_next;
    entry_t     skid_reg, skid_next;
    entry_t     in_entry;

    logic head_valid;
    logic skid_valid;
    logic accept;
    logic fire;

    assign head_valid = (state_reg != ST_EMPTY);
    assign skid_valid = (state_reg == ST_TWO);

    // Accept deliberately omits rst: every flop is held in reset anyway, and
    // keeping the reset net out of the next-state logic keeps it purely async.
    assign accept = bus.in_valid && (state_reg != ST_TWO);
    assign fire   = head_valid && bus.out_ready;

    always_comb begin
        in_entry.wen  = wen_filter(bus.in_wen, bus.in_addr == '0, ZERO_REG);
        in_entry.addr = bus.in_addr;
        in_entry.data = bus.in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_EMPTY;
            head_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            head_reg  <= head_next;
            skid_reg  <= skid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        skid_next  = skid_reg;
        if (flush) begin
            state_next    = ST_EMPTY;
            head_next.wen = 1'b0;
            skid_next.wen = 1'b0;
        end else begin
            unique case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next = ST_ONE;
                        head_next  = in_entry;
                    end
                end
                ST_ONE: begin
                    if (accept && fire) begin
                        head_next = in_entry;
                    end else if (accept) begin
                        state_next = ST_TWO;
                        skid_next  = in_entry;
                    end else if (fire) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (fire) begin
                        state_next = ST_ONE;
                        head_next  = skid_reg;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // in_ready is low during reset even though state already reads EMPTY.
    assign bus.in_ready  = rst && (state_reg != ST_TWO);
    assign bus.out_valid = head_valid;
    assign bus.out_wen   = head_valid && head_reg.wen;
    assign bus.out_addr  = head_reg.addr;
    assign bus.out_data  = head_reg.data;

    logic [AW-1:0] fwd_raddr [2];
    logic          fwd_hit   [2];
    logic [DW-1:0] fwd_data  [2];

    assign fwd_raddr[0]   = bus.fwd_raddr_a;
    assign fwd_raddr[1]   = bus.fwd_raddr_b;
    assign bus.fwd_hit_a  = fwd_hit[0];
    assign bus.fwd_hit_b  = fwd_hit[1];
    assign bus.fwd_data_a = fwd_data[0];
    assign bus.fwd_data_b = fwd_data[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            pip_fwd_cmp #(
                .AW       (AW),
                .DW       (DW),
                .ZERO_REG (ZERO_REG)
            ) u_cmp (
                .head_valid (head_valid),
                .head_wen   (head_reg.wen),
                .head_addr  (head_reg.addr),
                .head_data  (head_reg.data),
                .skid_valid (skid_valid),
                .skid_wen   (skid_reg.wen),
                .skid_addr  (skid_reg.addr),
                .skid_data  (skid_reg.data),
                .raddr      (fwd_raddr[gi]),
                .hit        (fwd_hit[gi]),
                .data       (fwd_data[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pip_wb_stage.sv
// Bench for pip_wb_stage: a FIFO-queue model checked every cycle plus
// directed vectors with hand-computed literal expectations.
module tb_pip_wb_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;

    pip_wb_stage_if #(.AW(4), .DW(16)) bus ();

    pip_wb_stage #(.AW(4), .DW(16), .ZERO_REG(1'b1)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        wen;
        logic [3:0]  addr;
        logic [15:0] data;
    } ent_t;

    ent_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Youngest held entry that writes the looked-up register wins; r0 never forwards.
    function automatic void fwd_model(input logic [3:0] ra, output logic hit, output logic [15:0] d);
        hit = 1'b0;
        d   = 16'h0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].wen && q[i].addr == ra && ra != 4'd0) begin
                hit = 1'b1;
                d   = q[i].data;
                break;
            end
        end
    endfunction

    // Model: at most two results in flight, leaving in arrival order.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
        end else begin
            bit   acc;
            bit   fir;
            ent_t e;
            acc = bus.in_valid && (q.size() < 2);
            fir = (q.size() > 0) && bus.out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (fir) begin
                    $display("[TB] wb addr=%0d data=%h wen=%0b", q[0].addr, q[0].data, q[0].wen);
                    void'(q.pop_front());
                end
                if (acc) begin
                    e.wen  = bus.in_wen && (bus.in_addr != 4'd0);
                    e.addr = bus.in_addr;
                    e.data = bus.in_data;
                    q.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic        h;
        logic [15:0] d;
        check("in_ready", {31'b0, bus.in_ready}, {31'b0, rst && (q.size() < 2)});
        check("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() > 0});
        if (q.size() > 0) begin
            check("out_wen", {31'b0, bus.out_wen}, {31'b0, q[0].wen});
            check("out_addr", {28'b0, bus.out_addr}, {28'b0, q[0].addr});
            check("out_data", {16'b0, bus.out_data}, {16'b0, q[0].data});
        end
        fwd_model(bus.fwd_raddr_a, h, d);
        check("fwd_hit_a", {31'b0, bus.fwd_hit_a}, {31'b0, h});
        check("fwd_data_a", {16'b0, bus.fwd_data_a}, {16'b0, d});
        fwd_model(bus.fwd_raddr_b, h, d);
        check("fwd_hit_b", {31'b0, bus.fwd_hit_b}, {31'b0, h});
        check("fwd_data_b", {16'b0, bus.fwd_data_b}, {16'b0, d});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [15:0] d);
        bus.in_valid = v;
        bus.in_wen   = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
    endtask

    initial begin
        int   idx;
        logic acc;
        bus.in_valid    = 1'b0;
        bus.in_wen      = 1'b0;
        bus.in_addr     = 4'd0;
        bus.in_data     = 16'h0;
        bus.out_ready   = 1'b0;
        bus.fwd_raddr_a = 4'd0;
        bus.fwd_raddr_b = 4'd0;

        // Reset state, inputs ignored while held
        #3;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rst_out_wen", {31'b0, bus.out_wen}, 32'd0);
        check("rst_out_addr", {28'b0, bus.out_addr}, 32'd0);
        check("rst_out_data", {16'b0, bus.out_data}, 32'd0);
        drive(1'b1, 4'd3, 16'h5555);
        tick();
        check("rst_ignore_in", {31'b0, bus.out_valid}, 32'd0);
        drive(1'b0, 4'd0, 16'h0);
        tick();
        rst = 1'b1;

        // Streaming with no bubbles
        bus.out_ready = 1'b1;
        drive(1'b1, 4'd3, 16'h1234);
        #1 check("stream_in_ready0", {31'b0, bus.in_ready}, 32'd1);
        tick();
        check("stream_addr3", {28'b0, bus.out_addr}, 32'd3);
        check("stream_data3", {16'b0, bus.out_data}, 32'h1234);
        check("stream_wen3", {31'b0, bus.out_wen}, 32'd1);
        drive(1'b1, 4'd5, 16'hBEEF);
        tick();
        check("stream_addr5", {28'b0, bus.out_addr}, 32'd5);
        check("stream_data5", {16'b0, bus.out_data}, 32'hBEEF);
        check("stream_in_ready1", {31'b0, bus.in_ready}, 32'd1);
        drive(1'b0, 4'd0, 16'h0);
        tick();
        check("stream_drained", {31'b0, bus.out_valid}, 32'd0);

        // Back-pressure: third beat held until space frees up
        bus.out_ready = 1'b0;
        drive(1'b1, 4'd1, 16'h0001);
        tick();
        drive(1'b1, 4'd2, 16'h0002);
        tick();
        check("bp_in_ready_full", {31'b0, bus.in_ready}, 32'd0);
        drive(1'b1, 4'd3, 16'h0003);
        tick();
        check("bp_head_held", {28'b0, bus.out_addr}, 32'd1);
        bus.out_ready = 1'b1;
        tick();
        check("bp_seq2", {28'b0, bus.out_addr}, 32'd2);
        tick();
        check("bp_seq3", {28'b0, bus.out_addr}, 32'd3);
        check("bp_seq3_data", {16'b0, bus.out_data}, 32'h0003);
        drive(1'b0, 4'd0, 16'h0);
        tick();
        check("bp_drained", {31'b0, bus.out_valid}, 32'd0);

        // Forward priority: skid beats head for the same register
        bus.out_ready = 1'b0;
        drive(1'b1, 4'd4, 16'hAAAA);
        tick();
        drive(1'b1, 4'd4, 16'hBBBB);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        bus.fwd_raddr_a = 4'd4;
        bus.fwd_raddr_b = 4'd9;
        #1;
        check("fwd_prio_hit_a", {31'b0, bus.fwd_hit_a}, 32'd1);
        check("fwd_prio_data_a", {16'b0, bus.fwd_data_a}, 32'hBBBB);
        check("fwd_miss_hit_b", {31'b0, bus.fwd_hit_b}, 32'd0);
        check("fwd_miss_data_b", {16'b0, bus.fwd_data_b}, 32'd0);

        // Flush from TWO with a pending beat
        flush = 1'b1;
        drive(1'b1, 4'd7, 16'h7777);
        #1 check("flush_ready_two", {31'b0, bus.in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, 4'd0, 16'h0);
        bus.fwd_raddr_a = 4'd7;
        #1;
        check("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("flush_fwd7", {31'b0, bus.fwd_hit_a}, 32'd0);

        // Flush from ONE discards a same-cycle accept
        drive(1'b1, 4'd6, 16'h6666);
        tick();
        bus.fwd_raddr_b = 4'd6;
        #1;
        check("fwd_head_hit_b", {31'b0, bus.fwd_hit_b}, 32'd1);
        check("fwd_head_data_b", {16'b0, bus.fwd_data_b}, 32'h6666);
        flush = 1'b1;
        drive(1'b1, 4'd7, 16'h7777);
        #1 check("flush_ready_one", {31'b0, bus.in_ready}, 32'd1);
        tick();
        flush = 1'b0;
        drive(1'b0, 4'd0, 16'h0);
        check("flush_accept_gone", {31'b0, bus.out_valid}, 32'd0);
        check("flush_fwd7_b", {31'b0, bus.fwd_hit_a}, 32'd0);

        // Zero register: travels but never writes or forwards
        drive(1'b1, 4'd0, 16'hFFFF);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        bus.fwd_raddr_a = 4'd0;
        #1;
        check("zero_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("zero_out_wen", {31'b0, bus.out_wen}, 32'd0);
        check("zero_out_data", {16'b0, bus.out_data}, 32'hFFFF);
        check("zero_fwd", {31'b0, bus.fwd_hit_a}, 32'd0);
        bus.out_ready = 1'b1;
        tick();

        // Asynchronous reset while full
        bus.out_ready = 1'b0;
        drive(1'b1, 4'hA, 16'hAAA1);
        tick();
        drive(1'b1, 4'hB, 16'hBBB2);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        bus.fwd_raddr_a = 4'hB;
        bus.fwd_raddr_b = 4'hA;
        #1;
        check("pre_rst_hit_a", {31'b0, bus.fwd_hit_a}, 32'd1);
        check("pre_rst_data_b", {16'b0, bus.fwd_data_b}, 32'hAAA1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("arst_out_wen", {31'b0, bus.out_wen}, 32'd0);
        check("arst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("arst_hit_a", {31'b0, bus.fwd_hit_a}, 32'd0);
        check("arst_hit_b", {31'b0, bus.fwd_hit_b}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 4'd8, 16'h8888);
        tick();
        check("post_rst_valid", {31'b0, bus.out_valid}, 32'd1);
        check("post_rst_addr", {28'b0, bus.out_addr}, 32'd8);
        check("post_rst_data", {16'b0, bus.out_data}, 32'h8888);
        drive(1'b0, 4'd0, 16'h0);
        tick();
        check("post_rst_drained", {31'b0, bus.out_valid}, 32'd0);

        // Mixed traffic: irregular write-port stalls, model checks every cycle
        idx = 0;
        for (int cyc = 0; cyc < 40 && idx < 12; cyc++) begin
            drive(1'b1, idx[3:0] + 4'd1, 16'h1111 * idx[15:0]);
            bus.in_wen    = (idx % 4) != 3;
            bus.out_ready = (cyc % 3) != 0;
            bus.fwd_raddr_a = idx[3:0];
            bus.fwd_raddr_b = idx[3:0] + 4'd1;
            #1 acc = bus.in_ready;
            tick();
            if (acc) idx++;
        end
        drive(1'b0, 4'd0, 16'h0);
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("mix_all_sent", idx, 32'd12);
        check("mix_drained", {31'b0, bus.out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
